// File: rtl/uart_tx_pkg.sv
// Shared constants and FSM state encoding for the streaming UART transmitter.
// UART_TX_PARITY_EN adds the PARITY state (8E1 frames); default build is 8N1.
package uart_tx_pkg;

    localparam int DATA_W          = 8;
    localparam int CLK_DIV_DEFAULT = 234;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO; DEPTH must be a power of two so pointers wrap naturally.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q;
    logic          do_push, do_pop;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_stream.sv
// Streaming UART transmitter: byte FIFO feeding an 8N1 serializer (8E1 when
// UART_TX_PARITY_EN is defined). txd is registered and trails state by one cycle.
module uart_tx_stream
    import uart_tx_pkg::*;
#(
    parameter int CLK_DIV    = CLK_DIV_DEFAULT,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int CW = $clog2(CLK_DIV + 1);

    tx_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              txd_q, txd_d;

    logic              fifo_full, fifo_empty, pop;
    logic [DATA_W-1:0] fifo_rdata;
    logic              baud_end;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .wdata (in_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign in_ready = !fifo_full;
    assign busy     = (state_q != ST_IDLE) || (fifo_level != '0);
    assign txd      = txd_q;
    assign baud_end = (cnt_q == CW'(CLK_DIV - 1));

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        data_d  = data_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    data_d  = fifo_rdata;
                    state_d = ST_START;
                end
            end
            ST_START: if (baud_end) state_d = ST_DATA;
            ST_DATA: begin
                if (baud_end) begin
                    bit_d = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
                    if (bit_q == 3'd7) state_d = ST_PARITY;
`else
                    if (bit_q == 3'd7) state_d = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: if (baud_end) state_d = ST_STOP;
`endif
            ST_STOP: begin
                // Chain straight into the next start bit when more data waits.
                if (baud_end) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        data_d  = fifo_rdata;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q || state_q == ST_IDLE || baud_end) cnt_d = '0;
        else                                                      cnt_d = cnt_q + CW'(1);

        case (state_q)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = data_q[bit_q];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: txd_d = ^data_q;
`endif
            default:   txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            txd_q   <= txd_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed bench for uart_tx_stream: vector table of bytes/frames plus
// hand-written sequences for latency, FIFO-full backpressure and mid-frame reset.
module tb_uart_tx_stream;
    localparam int CLK_DIV = 234;
    localparam int DEPTH   = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready, txd, busy;
    logic [3:0] fifo_level;

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0]  d;
        logic [10:0] frm;
    } vec_t;
    vec_t vt [5];

    uart_tx_stream #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .txd        (txd),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [10:0] mkframe(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {2'b01, d, 1'b0};
`endif
    endfunction

    // Waits for the start bit, then records every bit and checks each lasts CLK_DIV cycles.
    task automatic rx_frame(input int budget, output logic [10:0] frm,
                            output int waited, output int t0);
        bit ok = 0;
        bit wid_ok = 1;
        waited = 0;
        t0 = 0;
        frm = '0;
        while (waited < budget) begin
            @(negedge clk);
            waited++;
            if (txd === 1'b0) begin ok = 1; break; end
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL start_timeout: no start bit within %0d cycles", budget);
            return;
        end
        t0 = cyc;
        for (int i = 0; i < NB; i++) begin
            for (int c = 0; c < CLK_DIV; c++) begin
                if (i != 0 || c != 0) @(negedge clk);
                if (c == 0) frm[i] = txd;
                else if (txd !== frm[i]) wid_ok = 0;
            end
        end
        chk("bit_width", int'(wid_ok), 1);
    endtask

    initial begin
        logic [10:0] frm;
        int waited, t0, n0, lows;
        bit saw_full;

`ifdef UART_TX_PARITY_EN
        vt[0] = '{8'h41, 11'h482};
        vt[1] = '{8'h42, 11'h484};
        vt[2] = '{8'h43, 11'h686};
        vt[3] = '{8'h0D, 11'h61A};
        vt[4] = '{8'h0A, 11'h414};
`else
        vt[0] = '{8'h41, 11'h282};
        vt[1] = '{8'h42, 11'h284};
        vt[2] = '{8'h43, 11'h286};
        vt[3] = '{8'h0D, 11'h21A};
        vt[4] = '{8'h0A, 11'h214};
`endif

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_txd", int'(txd), 1);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_level", int'(fifo_level), 0);

        // Single "A": start edge two cycles after the accepting edge.
        in_data = 8'h41; in_valid = 1'b1;
        n0 = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("level_after_push", int'(fifo_level), 1);
        rx_frame(20, frm, waited, t0);
        chk("start_latency", t0 - n0, 2);
        chk("frame_A", int'(frm), int'(vt[0].frm));
        @(negedge clk);
        chk("busy_after_A", int'(busy), 0);

        // Table: five bytes pushed back-to-back, frames must chain with no idle gap.
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    in_data = vt[i].d; in_valid = 1'b1;
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    rx_frame((i == 0) ? 20 : 4 * CLK_DIV, frm, waited, t0);
                    chk($sformatf("frame_vec%0d", i), int'(frm), int'(vt[i].frm));
                    if (i > 0) chk($sformatf("gap_vec%0d", i), waited, 1);
                end
            end
        join
        @(negedge clk);
        chk("busy_after_burst", int'(busy), 0);
        chk("level_after_burst", int'(fifo_level), 0);

        // Backpressure: one byte in flight, then hold in_valid for 10 more.
        saw_full = 0;
        fork
            begin
                int k = 0;
                int guard = 0;
                bit acc;
                @(negedge clk);
                in_data = 8'h30; in_valid = 1'b1;
                @(negedge clk);
                in_valid = 1'b0;
                repeat (50) @(negedge clk);
                while (k < 10 && guard < 30000) begin
                    guard++;
                    in_data = 8'h31 + 8'(k); in_valid = 1'b1;
                    acc = in_ready;
                    if (!acc && !saw_full) begin
                        saw_full = 1;
                        chk("level_at_full", int'(fifo_level), DEPTH);
                        chk("accepted_before_full", k, DEPTH);
                    end
                    @(posedge clk);
                    if (acc) k++;
                    @(negedge clk);
                end
                in_valid = 1'b0;
                chk("all_ten_accepted", k, 10);
            end
            begin
                for (int i = 0; i < 11; i++) begin
                    rx_frame((i == 0) ? 20 : 4 * CLK_DIV, frm, waited, t0);
                    chk($sformatf("frame_fill%0d", i), int'(frm), int'(mkframe(8'h30 + 8'(i))));
                    if (i > 0) chk($sformatf("gap_fill%0d", i), waited, 1);
                end
            end
        join
        chk("saw_full", int'(saw_full), 1);
        @(negedge clk);
        chk("busy_after_fill", int'(busy), 0);

        // Reset during data bit 3 with a second byte still queued.
        in_data = 8'h41; in_valid = 1'b1;
        @(negedge clk);
        in_data = 8'h42;
        @(negedge clk);
        in_valid = 1'b0;
        waited = 0;
        while (waited < 20 && txd !== 1'b0) begin
            @(negedge clk);
            waited++;
        end
        chk("rst_test_start", int'(txd), 0);
        repeat (4 * CLK_DIV + CLK_DIV / 2) @(negedge clk);
        chk("pre_rst_bit3", int'(txd), 0);
        chk("pre_rst_level", int'(fifo_level), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_txd", int'(txd), 1);
        chk("mid_rst_level", int'(fifo_level), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        rst = 1'b0;
        lows = 0;
        repeat (12 * CLK_DIV) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        chk("no_frame_after_rst", lows, 0);
        chk("idle_busy_after_rst", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
